// File: rtl/hsv2rgb.sv
// Four-stage HSV-to-RGB pixel converter, one pixel per clock, fixed latency.
// Video timing flags ride alongside the data in a matching shift register.
module hsv2rgb #(
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsv_valid,
  input  logic [23:0] hsv_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        blank_in,
  output logic        rgb_valid,
  output logic [23:0] rgb_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        blank_out
);

  typedef struct packed {
    logic vld;
    logic hs;
    logic vs;
    logic bl;
  } flags_t;

  typedef struct packed {
    logic [7:0] s;
    logic [7:0] v;
    logic [7:0] rem;
    logic [2:0] region;
    logic       s_zero;
  } s1_t;

  typedef struct packed {
    logic [7:0] v;
    logic [7:0] p;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] region;
    logic       s_zero;
  } s2_t;

  typedef struct packed {
    logic [7:0] v;
    logic [7:0] p;
    logic [7:0] q;
    logic [7:0] t;
    logic [2:0] region;
    logic       s_zero;
  } s3_t;

  // Upper byte of an 8x8 unsigned product, truncated.
  function automatic logic [7:0] mul_hi(input logic [7:0] x, input logic [7:0] y);
    return 8'(({8'd0, x} * {8'd0, y}) >> 8);
  endfunction

  flags_t               flg_in;
  flags_t [LATENCY:1]   vld_pipe;

  assign flg_in = {hsv_valid, hsync_in, vsync_in, blank_in};
  assign {rgb_valid, hsync_out, vsync_out, blank_out} = vld_pipe[LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe <= '0;
    else        vld_pipe <= {vld_pipe[LATENCY-1:1], flg_in};
  end

  // Stage 1: hue sector by compare chain, offset within sector scaled by 6.
  logic [7:0] h, h_base, h_off, rem;
  logic [2:0] region;
  s1_t        s1_d, s1_q;

  always_comb begin
    h      = hsv_in[23:16];
    region = 3'd0;
    h_base = 8'd0;
    if      (h >= 8'd215) begin region = 3'd5; h_base = 8'd215; end
    else if (h >= 8'd172) begin region = 3'd4; h_base = 8'd172; end
    else if (h >= 8'd129) begin region = 3'd3; h_base = 8'd129; end
    else if (h >= 8'd86)  begin region = 3'd2; h_base = 8'd86;  end
    else if (h >= 8'd43)  begin region = 3'd1; h_base = 8'd43;  end
    h_off = h - h_base;
    rem   = (h_off << 2) + (h_off << 1);
    s1_d  = '{s: hsv_in[15:8], v: hsv_in[7:0], rem: rem, region: region,
              s_zero: (hsv_in[15:8] == 8'd0)};
  end

  // Stage 2: first-level products.
  s2_t s2_d, s2_q;

  always_comb begin
    s2_d = '{v: s1_q.v,
             p: mul_hi(s1_q.v, 8'd255 - s1_q.s),
             a: mul_hi(s1_q.s, s1_q.rem),
             b: mul_hi(s1_q.s, 8'd255 - s1_q.rem),
             region: s1_q.region, s_zero: s1_q.s_zero};
  end

  // Stage 3: falling (q) and rising (t) channel values.
  s3_t s3_d, s3_q;

  always_comb begin
    s3_d = '{v: s2_q.v, p: s2_q.p,
             q: mul_hi(s2_q.v, 8'd255 - s2_q.a),
             t: mul_hi(s2_q.v, 8'd255 - s2_q.b),
             region: s2_q.region, s_zero: s2_q.s_zero};
  end

  // Stage 4: sector mux; zero saturation forces grey.
  logic [23:0] rgb_d;

  always_comb begin
    rgb_d = {s3_q.v, s3_q.t, s3_q.p};
    if (s3_q.s_zero) rgb_d = {s3_q.v, s3_q.v, s3_q.v};
    else begin
      case (s3_q.region)
        3'd0:    rgb_d = {s3_q.v, s3_q.t, s3_q.p};
        3'd1:    rgb_d = {s3_q.q, s3_q.v, s3_q.p};
        3'd2:    rgb_d = {s3_q.p, s3_q.v, s3_q.t};
        3'd3:    rgb_d = {s3_q.p, s3_q.q, s3_q.v};
        3'd4:    rgb_d = {s3_q.t, s3_q.p, s3_q.v};
        default: rgb_d = {s3_q.v, s3_q.p, s3_q.q};
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      rgb_out <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
      rgb_out <= rgb_d;
    end
  end

endmodule

// File: tb/tb_hsv2rgb.sv
// Self-checking bench for hsv2rgb: directed scenarios plus random pixels
// scored against an arithmetic HSV model delayed by four cycles.
module tb_hsv2rgb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsv_valid;
  logic [23:0] hsv_in;
  logic        hsync_in, vsync_in, blank_in;
  logic        rgb_valid;
  logic [23:0] rgb_out;
  logic        hsync_out, vsync_out, blank_out;

  hsv2rgb dut (
    .clk(clk), .rst_n(rst_n), .hsv_valid(hsv_valid), .hsv_in(hsv_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_in(blank_in),
    .rgb_valid(rgb_valid), .rgb_out(rgb_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .blank_out(blank_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit        vld;
    bit        hs;
    bit        vs;
    bit        bl;
    bit [23:0] rgb;
  } exp_t;

  exp_t pipe [4];
  int   checks = 0;
  int   errors = 0;

  function automatic bit [23:0] ref_rgb(input int h, input int s, input int v);
    int region, rem, p, a, b, q, t, r, g, bl;
    region = h / 43;
    rem    = ((h - 43 * region) * 6) % 256;
    p = (v * (255 - s)) / 256;
    a = (s * rem) / 256;
    b = (s * (255 - rem)) / 256;
    q = (v * (255 - a)) / 256;
    t = (v * (255 - b)) / 256;
    case (region)
      0:       begin r = v; g = t; bl = p; end
      1:       begin r = q; g = v; bl = p; end
      2:       begin r = p; g = v; bl = t; end
      3:       begin r = p; g = q; bl = v; end
      4:       begin r = t; g = p; bl = v; end
      default: begin r = v; g = p; bl = q; end
    endcase
    if (s == 0) begin r = v; g = v; bl = v; end
    return {r[7:0], g[7:0], bl[7:0]};
  endfunction

  // Drive one input cycle at a falling edge; return what should be visible
  // on the outputs at the next falling edge.
  task automatic cycle(input bit vld, input bit [23:0] hsv, input bit hs,
                       input bit vs, input bit bl, output exp_t due);
    pipe[3] = pipe[2];
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = {vld, hs, vs, bl, ref_rgb(int'(hsv[23:16]), int'(hsv[15:8]), int'(hsv[7:0]))};
    hsv_valid = vld; hsv_in = hsv;
    hsync_in = hs; vsync_in = vs; blank_in = bl;
    @(negedge clk);
    due = pipe[3];
  endtask

  task automatic drain();
    exp_t d;
    repeat (4) cycle(1'b0, 24'h0, 1'b0, 1'b0, 1'b0, d);
  endtask

  task automatic test_reset();
    exp_t due;
    rst_n = 1'b0;
    hsv_valid = 1'b1; hsv_in = 24'hFFFFFF;
    hsync_in = 1'b1; vsync_in = 1'b1; blank_in = 1'b1;
    for (int i = 0; i < 4; i++) pipe[i] = '0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({rgb_valid, hsync_out, vsync_out, blank_out, rgb_out} !== 28'h0) begin
        errors++;
        $display("FAIL reset_hold got %b_%h exp 0000_000000",
                 {rgb_valid, hsync_out, vsync_out, blank_out}, rgb_out);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 24'hFFFFFF, 1'b0, 1'b0, 1'b0, due);
      checks++;
      if (rgb_valid !== (i >= 3)) begin
        errors++;
        $display("FAIL reset_release_valid cyc %0d got %b exp %b", i, rgb_valid, (i >= 3));
      end
      if (i >= 3) begin
        checks++;
        if (rgb_out !== 24'hFF000F) begin
          errors++;
          $display("FAIL reset_release_rgb cyc %0d got %h exp ff000f", i, rgb_out);
        end
      end
    end
    drain();
  endtask

  task automatic test_primaries();
    exp_t      due;
    bit [23:0] hsv_t [4] = '{24'h00FFFF, 24'h55FFFF, 24'hABFFFF, 24'h2BFFFF};
    bit [23:0] rgb_t [4] = '{24'hFF0000, 24'h03FF00, 24'h0003FF, 24'hFEFF00};
    for (int i = 0; i < 8; i++) begin
      cycle(i < 4, (i < 4) ? hsv_t[i] : 24'h0, 1'b0, 1'b0, 1'b0, due);
      checks++;
      if (rgb_valid !== (i >= 3 && i <= 6)) begin
        errors++;
        $display("FAIL prim_valid cyc %0d got %b exp %b", i, rgb_valid, (i >= 3 && i <= 6));
      end
      if (i >= 3 && i <= 6) begin
        checks++;
        if (rgb_out !== rgb_t[i-3]) begin
          errors++;
          $display("FAIL prim_rgb hsv %h got %h exp %h", hsv_t[i-3], rgb_out, rgb_t[i-3]);
        end
      end
    end
    drain();
  endtask

  task automatic test_grey();
    exp_t due;
    for (int i = 0; i < 260; i++) begin
      cycle(i < 256, {i[7:0], 8'h00, 8'h80}, 1'b0, 1'b0, 1'b0, due);
      checks++;
      if (rgb_valid !== (i >= 3 && i <= 258)) begin
        errors++;
        $display("FAIL grey_valid cyc %0d got %b exp %b", i, rgb_valid, (i >= 3 && i <= 258));
      end
      if (i >= 3 && i <= 258) begin
        checks++;
        if (rgb_out !== 24'h808080) begin
          errors++;
          $display("FAIL grey_rgb h %0d got %h exp 808080", i - 3, rgb_out);
        end
      end
    end
    drain();
  endtask

  task automatic test_sync();
    exp_t due;
    for (int i = 0; i < 20; i++) begin
      cycle(i < 16, {i[3:0], 4'h0, 8'hC0, 8'hA0}, (i == 3), (i >= 6 && i <= 8),
            1'($urandom_range(1)), due);
      checks++;
      if (hsync_out !== (i == 6) || vsync_out !== (i >= 9 && i <= 11)) begin
        errors++;
        $display("FAIL sync_edges cyc %0d got hs %b vs %b exp hs %b vs %b", i,
                 hsync_out, vsync_out, (i == 6), (i >= 9 && i <= 11));
      end
      checks++;
      if ({rgb_valid, blank_out} !== {due.vld, due.bl}) begin
        errors++;
        $display("FAIL sync_valid_blank cyc %0d got %b exp %b", i,
                 {rgb_valid, blank_out}, {due.vld, due.bl});
      end
      if (due.vld) begin
        checks++;
        if (rgb_out !== due.rgb) begin
          errors++;
          $display("FAIL sync_rgb cyc %0d got %h exp %h", i, rgb_out, due.rgb);
        end
      end
    end
    drain();
  endtask

  task automatic test_reset_mid();
    exp_t due;
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 24'($urandom), 1'b1, 1'b1, 1'b1, due);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rgb_valid, hsync_out, vsync_out, blank_out, rgb_out} !== 28'h0) begin
      errors++;
      $display("FAIL midreset_clear got %b_%h exp 0000_000000",
               {rgb_valid, hsync_out, vsync_out, blank_out}, rgb_out);
    end
    for (int i = 0; i < 4; i++) pipe[i] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cycle(k == 0, (k == 0) ? 24'h00FFFF : 24'h0, 1'b0, 1'b0, 1'b0, due);
      checks++;
      if (rgb_valid !== (k == 3)) begin
        errors++;
        $display("FAIL midreset_valid cyc %0d got %b exp %b", k, rgb_valid, (k == 3));
      end
      if (k == 3) begin
        checks++;
        if (rgb_out !== 24'hFF0000) begin
          errors++;
          $display("FAIL midreset_rgb got %h exp ff0000", rgb_out);
        end
      end
    end
    drain();
  endtask

  task automatic test_random();
    exp_t    due;
    bit [7:0] hb [12] = '{8'd42, 8'd43, 8'd85, 8'd86, 8'd128, 8'd129,
                          8'd171, 8'd172, 8'd214, 8'd215, 8'd255, 8'd0};
    for (int i = 0; i < 248; i++) begin
      if (i < 48)
        cycle(1'b1, {hb[i % 12], 8'($urandom), 8'($urandom)}, 1'b0, 1'b0, 1'b0, due);
      else if (i < 244)
        cycle(1'($urandom_range(1)), 24'($urandom), 1'($urandom_range(1)),
              1'($urandom_range(1)), 1'($urandom_range(1)), due);
      else
        cycle(1'b0, 24'h0, 1'b0, 1'b0, 1'b0, due);
      checks++;
      if ({rgb_valid, hsync_out, vsync_out, blank_out} !== {due.vld, due.hs, due.vs, due.bl}) begin
        errors++;
        $display("FAIL rand_flags cyc %0d got %b exp %b", i,
                 {rgb_valid, hsync_out, vsync_out, blank_out}, {due.vld, due.hs, due.vs, due.bl});
      end
      if (due.vld) begin
        checks++;
        if (rgb_out !== due.rgb) begin
          errors++;
          $display("FAIL rand_rgb cyc %0d got %h exp %h", i, rgb_out, due.rgb);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_primaries();
    test_grey();
    test_sync();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hsv2rgb.md
# hsv2rgb

Pipelined HSV-to-RGB converter placed directly downstream of the saturation/brightness enhancement stage in the passport video path. It accepts one 24-bit HSV pixel per clock, with video sync/blank flags, and emits the matching 24-bit RGB pixel to the VGA output mux. Latency is fixed at 4 clocks and throughput is one pixel per clock. The sync/blank flags are delayed by the same amount so timing stays aligned with the pixels.

## Interface
- `LATENCY`, 4: pipeline depth. Fixed; informational only and must not be overridden.
- `clk` in 1: pixel clock. All state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset. Clears all pipeline registers.
- `hsv_valid` in 1: `hsv_in` holds a real pixel this cycle.
- `hsv_in` in 24: H[23:16] (0..255 spans 0..360°), S[15:8], V[7:0].
- `hsync_in`, `vsync_in`, `blank_in` in 1 each: video timing flags that accompany `hsv_in`.
- `rgb_valid` out 1: `hsv_valid` delayed by 4 clocks.
- `rgb_out` out 24: R[23:16], G[15:8], B[7:0].
- `hsync_out`, `vsync_out`, `blank_out` out 1 each: the input flags delayed by 4 clocks.

## Operation
- Stage 1:
  - region = 5 if H≥215; 4 if H≥172; 3 if H≥129; 2 if H≥86; 1 if H≥43; else 0. Use a compare chain, no divider.
  - rem = (H − 43·region)·6, 8-bit. Never exceeds 252.
  - Register S, V, region, rem, and s_zero = (S==0).
- Stage 2:
  - p = (V·(255−S))[15:8]
  - a = (S·rem)[15:8]
  - b = (S·(255−rem))[15:8]
  - All products are 16-bit unsigned. Keep the upper byte (truncate, no rounding).
- Stage 3:
  - q = (V·(255−a))[15:8]
  - t = (V·(255−b))[15:8]
- Stage 4 output mux, giving (R,G,B):
  - region 0: (V,t,p)
  - region 1: (q,V,p)
  - region 2: (p,V,t)
  - region 3: (p,q,V)
  - region 4: (t,p,V)
  - region 5: (V,p,q)
  - If s_zero: R=G=B=V, overriding the region mux.
- Data and flags advance every clock regardless of valid. There is no stall and no backpressure.
- When `hsv_valid`=0, the data path still computes, but `rgb_valid`=0 marks the output as don't-care.
- No saturation logic is needed. Every intermediate stays in 0..255 by construction.

## Timing
- Input sampled at edge N appears on all outputs after edge N+4.
- A fresh pixel can be accepted every cycle. Back-to-back pixels stay in order with no bubbles.
- Reset values, while `rst_n`=0 and after release:
  - `rgb_out`=0x000000, `rgb_valid`=0, `hsync_out`=0, `vsync_out`=0, `blank_out`=0.
  - All internal stage registers are 0.
- Reset asserted mid-stream:
  - All in-flight pixels are discarded immediately (asynchronous).
  - The first pixel accepted after deassertion appears 4 clocks later.
  - No stale `rgb_valid` pulse is allowed.
- Every flag takes exactly the same delay as its pixel. A flag toggle at input edge N appears at output edge N+4.
- Hue boundaries:
  - H=42 → region 0, rem 252.
  - H=43 → region 1, rem 0.
  - H=255 → region 5, rem 240.
  - There is no wrap-around past 255.

## Test plan
- Reset: hold `rst_n`=0 while driving `hsv_in`=0xFFFFFF with valid high → all outputs stay 0. Release `rst_n` → `rgb_valid` rises exactly 4 clocks later.
- Primaries, streamed back-to-back with valid high, expected at 4-clock latency with no bubbles:
  - 0x00FFFF → 0xFF0000
  - 0x55FFFF → 0x03FF00
  - 0xABFFFF → 0x0003FF
  - 0x2BFFFF → 0xFEFF00
- Grey: H sweeps 0..255 with S=0, V=0x80 → every output is 0x808080.
- Sync alignment: pulse `hsync_in` for 1 cycle and `vsync_in` for 3 cycles on a ramp of pixels → each output flag edge lines up with its pixel, 4 clocks after the input.
- Reset mid-stream: assert `rst_n`=0 for 1 cycle while 3 pixels are in flight → those pixels never produce an `rgb_valid` pulse. The next pixel 0x00FFFF emerges as 0xFF0000 four clocks after acceptance.
- Region-boundary sweep: random S/V at H=42, 43, 85, 86, 214, 215, 255 → output matches a bit-exact reference model using the same truncation rules.
